// File: rtl/alu.sv
// Registered 32-bit integer ALU for the RV32I execute stage.
//
// Four functional units (add/sub, less-than, boolean, barrel shifter) are computed in
// parallel; each output is gated by its bit of the one-hot select and the gated outputs
// are ORed together. The combined value is registered into o_result every rising edge.
//
// Ports:
//   i_clk        clock, all state updates on the rising edge
//   i_rst        synchronous active-high reset, clears o_result
//   i_op_a       operand A
//   i_op_b       operand B; shift amount is i_op_b[4:0]
//   i_sub        add/sub: subtract; compare: signed; right shift: arithmetic
//   i_bool_op    00 xor, 01 pass B, 10 or, 11 and
//   i_op_sel     one-hot unit select: [0] add/sub, [1] less-than, [2] boolean, [3] shift
//   i_shift_dir  0 = left, 1 = right
//   o_result     registered result, one cycle after the inputs
module alu (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic        i_sub,
    input  logic [1:0]  i_bool_op,
    input  logic [3:0]  i_op_sel,
    input  logic        i_shift_dir,
    output logic [31:0] o_result
);

    logic [31:0] addsub_out;
    logic [32:0] cmp_diff;
    logic        cmp_lt;
    logic [31:0] lt_out;
    logic [31:0] bool_out;
    logic [4:0]  shamt;
    logic        shift_fill;
    logic [31:0] shl_out;
    logic [63:0] shr_ext;
    logic [31:0] shr_out;
    logic [31:0] shift_out;
    logic [31:0] result_d;

    // Add/sub: A + (B ^ {32{sub}}) + sub gives A + B or A + ~B + 1.
    assign addsub_out = i_op_a + (i_op_b ^ {32{i_sub}}) + {31'b0, i_sub};

    // The comparator owns its own subtractor so that i_sub (signedness here) never
    // changes what the add/sub unit produces when both are selected.
    // Carry out of A + ~B + 1 is 1 when A >= B unsigned, so borrow = ~carry.
    assign cmp_diff = {1'b0, i_op_a} + {1'b0, ~i_op_b} + 33'd1;

    always_comb begin
        cmp_lt = ~cmp_diff[32];
        if (i_sub) begin
            // Signed: differing signs decide directly (negative A is smaller),
            // otherwise the difference cannot overflow and its sign is the answer.
            cmp_lt = (i_op_a[31] ^ i_op_b[31]) ? i_op_a[31] : cmp_diff[31];
        end
    end

    assign lt_out = {31'b0, cmp_lt};

    always_comb begin
        bool_out = 32'h0;
        case (i_bool_op)
            2'b00:   bool_out = i_op_a ^ i_op_b;
            2'b01:   bool_out = i_op_b;
            2'b10:   bool_out = i_op_a | i_op_b;
            2'b11:   bool_out = i_op_a & i_op_b;
            default: bool_out = 32'h0;
        endcase
    end

    // Barrel shifter. The fill bit is ANDed with the direction so that an undefined
    // i_sub on a left shift cannot reach the result.
    assign shamt      = i_op_b[4:0];
    assign shift_fill = i_shift_dir & i_sub & i_op_a[31];
    assign shl_out    = i_op_a << shamt;
    assign shr_ext    = {{32{shift_fill}}, i_op_a} >> shamt;
    assign shr_out    = shr_ext[31:0];
    assign shift_out  = i_shift_dir ? shr_out : shl_out;

    // AND-OR output mux: gate each unit before the OR so unselected units whose
    // don't-care inputs are undefined contribute clean zeros.
    assign result_d = (addsub_out & {32{i_op_sel[0]}})
                    | (lt_out     & {32{i_op_sel[1]}})
                    | (bool_out   & {32{i_op_sel[2]}})
                    | (shift_out  & {32{i_op_sel[3]}});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_result <= 32'h0;
        end else begin
            o_result <= result_d;
        end
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu. Each task drives its own vectors and compares
// o_result 1 ns after the rising edge that registered them.
module tb_alu;

    logic        i_clk;
    logic        i_rst;
    logic [31:0] i_op_a;
    logic [31:0] i_op_b;
    logic        i_sub;
    logic [1:0]  i_bool_op;
    logic [3:0]  i_op_sel;
    logic        i_shift_dir;
    logic [31:0] o_result;

    int checks;
    int errors;

    alu dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_op_a      (i_op_a),
        .i_op_b      (i_op_b),
        .i_sub       (i_sub),
        .i_bool_op   (i_bool_op),
        .i_op_sel    (i_op_sel),
        .i_shift_dir (i_shift_dir),
        .o_result    (o_result)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Drive one operation, let one edge register it, then sample 1 ns later.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [1:0] bop, input logic [3:0] sel, input logic dir);
        i_op_a      = a;
        i_op_b      = b;
        i_sub       = sub;
        i_bool_op   = bop;
        i_op_sel    = sel;
        i_shift_dir = dir;
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        apply(32'd5, 32'd6, 1'b0, 2'b00, 4'b0001, 1'b0);
        apply(32'd5, 32'd6, 1'b0, 2'b00, 4'b0001, 1'b0);
        checks++;
        if (o_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_initial: got %h expected %h", o_result, 32'h0);
        end
        i_rst = 1'b0;
        // First edge after deassertion produces the first valid result.
        apply(32'd5, 32'd6, 1'b0, 2'b00, 4'b0001, 1'b0);
        checks++;
        if (o_result !== 32'd11) begin
            errors++;
            $display("FAIL reset_first_result: got %h expected %h", o_result, 32'd11);
        end
        // Reset asserted with an add pending overrides the add.
        i_rst = 1'b1;
        apply(32'd1234, 32'd5678, 1'b0, 2'b00, 4'b0001, 1'b0);
        checks++;
        if (o_result !== 32'h0) begin
            errors++;
            $display("FAIL reset_pending_add: got %h expected %h", o_result, 32'h0);
        end
        i_rst = 1'b0;
    endtask

    task automatic test_add();
        logic [31:0] av [5] = '{32'd5, 32'd0, 32'd1234, 32'hAA, 32'hFFFF_FFFF};
        logic [31:0] bv [5] = '{32'd6, 32'd0, 32'd5678, 32'h55, 32'd1};
        logic [31:0] ev [5] = '{32'd11, 32'd0, 32'd6912, 32'hFF, 32'h0};
        for (int i = 0; i < 5; i++) begin
            apply(av[i], bv[i], 1'b0, 2'bxx, 4'b0001, 1'bx);
            checks++;
            if (o_result !== ev[i]) begin
                errors++;
                $display("FAIL add[%0d]: got %h expected %h", i, o_result, ev[i]);
            end
        end
    endtask

    task automatic test_sub();
        logic [31:0] av [4] = '{32'd5, 32'd1234, 32'hAA, 32'd0};
        logic [31:0] bv [4] = '{32'd6, 32'd5678, 32'h55, 32'd0};
        logic [31:0] ev [4] = '{32'hFFFF_FFFF, 32'hFFFF_EEA4, 32'h55, 32'h0};
        for (int i = 0; i < 4; i++) begin
            apply(av[i], bv[i], 1'b1, 2'bxx, 4'b0001, 1'bx);
            checks++;
            if (o_result !== ev[i]) begin
                errors++;
                $display("FAIL sub[%0d]: got %h expected %h", i, o_result, ev[i]);
            end
        end
    endtask

    task automatic test_bool();
        // 1234 = 0x04D2, 5678 = 0x162E
        logic [31:0] av [7] = '{32'd1234, 32'd1234, 32'd1234, 32'd1234, 32'd5, 32'd5, 32'd5};
        logic [31:0] bv [7] = '{32'd5678, 32'd5678, 32'd5678, 32'd5678, 32'd6, 32'd6, 32'd6};
        logic [1:0]  ov [7] = '{2'b00, 2'b10, 2'b11, 2'b01, 2'b00, 2'b10, 2'b11};
        logic [31:0] ev [7] = '{32'h12FC, 32'h16FE, 32'h0402, 32'd5678, 32'd3, 32'd7, 32'd4};
        for (int i = 0; i < 7; i++) begin
            apply(av[i], bv[i], 1'bx, ov[i], 4'b0100, 1'bx);
            checks++;
            if (o_result !== ev[i]) begin
                errors++;
                $display("FAIL bool[%0d]: got %h expected %h", i, o_result, ev[i]);
            end
        end
    endtask

    task automatic test_shift();
        apply(32'h0000_FFFF, 32'd8, 1'bx, 2'bxx, 4'b1000, 1'b0);
        checks++;
        if (o_result !== 32'h00FF_FF00) begin
            errors++;
            $display("FAIL shift_left: got %h expected %h", o_result, 32'h00FF_FF00);
        end
        apply(32'h0000_FFFF, 32'd8, 1'b0, 2'bxx, 4'b1000, 1'b1);
        checks++;
        if (o_result !== 32'h0000_00FF) begin
            errors++;
            $display("FAIL shift_right_logical: got %h expected %h", o_result, 32'h0000_00FF);
        end
        apply(32'hF000_FFFF, 32'd8, 1'b0, 2'bxx, 4'b1000, 1'b1);
        checks++;
        if (o_result !== 32'h00F0_00FF) begin
            errors++;
            $display("FAIL shift_right_logical_neg: got %h expected %h", o_result, 32'h00F0_00FF);
        end
        apply(32'hF000_FFFF, 32'd8, 1'b1, 2'bxx, 4'b1000, 1'b1);
        checks++;
        if (o_result !== 32'hFFF0_00FF) begin
            errors++;
            $display("FAIL shift_right_arith: got %h expected %h", o_result, 32'hFFF0_00FF);
        end
        // Upper bits of B are ignored: 0x28 shifts by 8.
        apply(32'h0000_FFFF, 32'h28, 1'bx, 2'bxx, 4'b1000, 1'b0);
        checks++;
        if (o_result !== 32'h00FF_FF00) begin
            errors++;
            $display("FAIL shift_b_upper_ignored: got %h expected %h", o_result, 32'h00FF_FF00);
        end
        apply(32'hF000_FFFF, 32'd0, 1'b1, 2'bxx, 4'b1000, 1'b1);
        checks++;
        if (o_result !== 32'hF000_FFFF) begin
            errors++;
            $display("FAIL shift_zero: got %h expected %h", o_result, 32'hF000_FFFF);
        end
        apply(32'h8000_0001, 32'd31, 1'b1, 2'bxx, 4'b1000, 1'b1);
        checks++;
        if (o_result !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL shift_arith_31: got %h expected %h", o_result, 32'hFFFF_FFFF);
        end
        apply(32'h8000_0001, 32'd31, 1'bx, 2'bxx, 4'b1000, 1'b0);
        checks++;
        if (o_result !== 32'h8000_0000) begin
            errors++;
            $display("FAIL shift_left_31: got %h expected %h", o_result, 32'h8000_0000);
        end
    endtask

    task automatic test_less_than();
        logic [31:0] av [6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1, 32'd1, 32'd7, 32'h7FFF_FFFF};
        logic [31:0] bv [6] = '{32'd1, 32'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd7, 32'h8000_0000};
        logic        sv [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] ev [6] = '{32'd1, 32'd0, 32'd0, 32'd1, 32'd0, 32'd1};
        for (int i = 0; i < 6; i++) begin
            apply(av[i], bv[i], sv[i], 2'bxx, 4'b0010, 1'bx);
            checks++;
            if (o_result !== ev[i]) begin
                errors++;
                $display("FAIL less_than[%0d]: got %h expected %h", i, o_result, ev[i]);
            end
        end
    endtask

    task automatic test_op_sel();
        apply(32'd5, 32'd6, 1'b0, 2'b00, 4'b0000, 1'b0);
        checks++;
        if (o_result !== 32'h0) begin
            errors++;
            $display("FAIL op_sel_none: got %h expected %h", o_result, 32'h0);
        end
        // add (0xB) OR xor (0x3)
        apply(32'd5, 32'd6, 1'b0, 2'b00, 4'b0101, 1'b0);
        checks++;
        if (o_result !== 32'hB) begin
            errors++;
            $display("FAIL op_sel_multi: got %h expected %h", o_result, 32'hB);
        end
    endtask

    task automatic test_back_to_back();
        // Each new op is driven right after the previous edge; result lags by one edge.
        apply(32'd100, 32'd23, 1'b0, 2'bxx, 4'b0001, 1'bx);
        checks++;
        if (o_result !== 32'd123) begin
            errors++;
            $display("FAIL b2b_0: got %h expected %h", o_result, 32'd123);
        end
        apply(32'd100, 32'd23, 1'b1, 2'bxx, 4'b0001, 1'bx);
        checks++;
        if (o_result !== 32'd77) begin
            errors++;
            $display("FAIL b2b_1: got %h expected %h", o_result, 32'd77);
        end
        apply(32'hF0F0_0000, 32'h0FF0_FFFF, 1'bx, 2'b11, 4'b0100, 1'bx);
        checks++;
        if (o_result !== 32'h00F0_0000) begin
            errors++;
            $display("FAIL b2b_2: got %h expected %h", o_result, 32'h00F0_0000);
        end
        apply(32'd1, 32'd4, 1'bx, 2'bxx, 4'b1000, 1'b0);
        checks++;
        if (o_result !== 32'd16) begin
            errors++;
            $display("FAIL b2b_3: got %h expected %h", o_result, 32'd16);
        end
        // Hold inputs, change nothing: result is recomputed from the same operands.
        @(posedge i_clk);
        #1;
        checks++;
        if (o_result !== 32'd16) begin
            errors++;
            $display("FAIL b2b_hold: got %h expected %h", o_result, 32'd16);
        end
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        i_rst       = 1'b1;
        i_op_a      = 32'h0;
        i_op_b      = 32'h0;
        i_sub       = 1'b0;
        i_bool_op   = 2'b00;
        i_op_sel    = 4'b0000;
        i_shift_dir = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_bool();
        test_shift();
        test_less_than();
        test_op_sel();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
